// File: rtl/store_merge_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// store_merge_ctrl_pkg
// Shared definitions for the store-merge controller: request size encodings,
// sub-word lane masks, FSM state encodings, the registered request record
// and the alignment/legality rule used when a request is accepted.
// ---------------------------------------------------------------------------
package store_merge_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_BYTE    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } req_size_e;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_WR   = 3'd3,
    ST_RSP  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Request fields captured on accept and held for the whole transaction.
  typedef struct packed {
    logic        we;
    req_size_e   size;
    logic        is_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // True for requests that complete with an error and never touch memory.
  function automatic logic req_is_bad(req_size_e size, logic [1:0] lane);
    case (size)
      SIZE_WORD: return lane != 2'b00;
      SIZE_HALF: return lane[0];
      SIZE_BYTE: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_ctrl_lane_merge.sv
// ---------------------------------------------------------------------------
// store_merge_ctrl_lane_merge
// Purely combinational lane logic for the store-merge controller.
//   size        : access size (word / halfword / byte)
//   lane        : byte address within the word (ADDR[1:0])
//   is_signed   : sign-extend the extracted load lane
//   wdata       : right-justified store data
//   old_word    : word read back from memory
//   merged_word : old_word with the addressed lane replaced by wdata
//                 (wdata unchanged for a word access)
//   load_data   : addressed lane of old_word, zero/sign extended to 32 bits
// ---------------------------------------------------------------------------
module store_merge_ctrl_lane_merge
  import store_merge_ctrl_pkg::*;
(
  input  req_size_e   size,
  input  logic [1:0]  lane,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [31:0] mask;
  logic [4:0]  shamt;
  logic [31:0] lane_bits;

  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can infer a latch.
    mask  = 32'hFFFF_FFFF;
    shamt = 5'd0;
    case (size)
      SIZE_BYTE: begin
        mask  = BYTE_MASK;
        shamt = {lane, 3'b000};
      end
      SIZE_HALF: begin
        mask  = HALF_MASK;
        shamt = {lane[1], 4'b0000};
      end
      default: ;
    endcase

    merged_word = (old_word & ~(mask << shamt)) | ((wdata & mask) << shamt);

    lane_bits = old_word >> shamt;
    case (size)
      SIZE_BYTE: load_data = {{24{is_signed & lane_bits[7]}},  lane_bits[7:0]};
      SIZE_HALF: load_data = {{16{is_signed & lane_bits[15]}}, lane_bits[15:0]};
      default:   load_data = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_ctrl.sv
// ---------------------------------------------------------------------------
// store_merge_ctrl
// Single-outstanding CPU load/store controller in front of a word-wide
// memory. Sub-word stores are done as read-modify-write; loads read the
// word and return the addressed lane extended to 32 bits. Misaligned or
// illegal-size requests complete with an error and never access memory.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only when idle)
//   req_we/size/signed  : store/load, access size, load extension mode
//   req_addr/req_wdata  : byte address, right-justified store data
//   rsp_valid/err/rdata : one-cycle completion pulse, error flag, load data
//   mem_en/we/addr      : word-memory strobe, write enable, aligned address
//   mem_wdata/mem_rdata : write word, read word (valid one cycle after read)
// All outputs are registered.
// ---------------------------------------------------------------------------
module store_merge_ctrl
  import store_merge_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        mem_en_q,    mem_en_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic [31:0] merged_word;
  logic [31:0] load_data;

  assign accept = req_valid & req_ready_q;

  // req_d is the request being worked on: the live inputs in the accept
  // cycle, the captured copy afterwards. old_word is only meaningful in WT,
  // which is the only state whose successor uses the lane results.
  store_merge_ctrl_lane_merge u_lane_merge (
    .size        (req_d.size),
    .lane        (req_d.addr[1:0]),
    .is_signed   (req_d.is_signed),
    .wdata       (req_d.wdata),
    .old_word    (mem_rdata),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'd0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = '{we:        req_we,
                    size:      req_size_e'(req_size),
                    is_signed: req_signed,
                    addr:      req_addr,
                    wdata:     req_wdata};
          if (req_is_bad(req_size_e'(req_size), req_addr[1:0])) begin
            state_d = ST_ERR;
          end else if (req_we && req_size_e'(req_size) == SIZE_WORD) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_WT;
      ST_WT:   state_d = req_q.we ? ST_WR : ST_RSP;
      ST_WR,
      ST_RSP,
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they appear,
    // registered, in the same cycle as that state.
    case (state_d)
      ST_RD: begin
        mem_en_d   = 1'b1;
        mem_addr_d = {req_d.addr[31:2], 2'b00};
      end
      ST_WR: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = {req_d.addr[31:2], 2'b00};
        mem_wdata_d = merged_word;
        rsp_valid_d = 1'b1;
      end
      ST_RSP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
      end
      ST_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: ;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset drops any transaction in flight, so nothing is written or
      // answered for it afterwards.
      state_q     <= ST_IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_ctrl.sv
// ---------------------------------------------------------------------------
// tb_store_merge_ctrl
// Self-checking bench for store_merge_ctrl. A word memory model answers the
// DUT's strobes; a byte-array reference model predicts load results, memory
// contents, latencies and error outcomes.
// ---------------------------------------------------------------------------
module tb_store_merge_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  // Memory seen by the DUT: 16 words covering byte addresses 0x00..0x3F.
  logic [31:0] tb_mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_val = 32'd0;

  // Reference model: plain byte-addressed memory.
  logic [7:0]  ref_bytes [64];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int wr_cnt    = 0;
  int rsp_cnt   = 0;
  int acc_cnt   = 0;

  store_merge_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) tb_mem[pre_idx] = pre_val;
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[5:2]] = mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[5:2]];
    end
  end

  always @(negedge clk) begin
    if (mem_en && mem_we) wr_cnt++;
    if (rsp_valid)        rsp_cnt++;
  end

  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) acc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 4 : ((s == 2'b01) ? 2 : 1);
  endfunction

  function automatic logic ref_bad(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b00 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[5:2]) * 4;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] s, input logic sgn, input logic [31:0] a);
    logic [31:0] v;
    int n;
    int b;
    n = nbytes(s);
    b = int'(a[5:0]);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[b+i];
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a[5:0]);
    for (int i = 0; i < nbytes(s); i++) ref_bytes[b+i] = d[8*i +: 8];
  endtask

  // Loads one memory word into both the DUT-side memory and the reference.
  task automatic set_word(input int idx, input logic [31:0] val);
    pre_idx = 4'(idx);
    pre_val = val;
    pre_en  = 1'b1;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = val[8*i +: 8];
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // One complete transaction with cycle-by-cycle observation.
  task automatic run_txn(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] o_rdata, output logic [31:0] o_wdata);
    logic        bad;
    int          exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_rdata, exp_word, aligned;
    int          lat, n_rd, n_wr, rd_at, wr_at;
    logic        got_err;
    logic [31:0] got_rdata, rd_addr, wr_addr, wr_data;

    bad       = ref_bad(size, addr);
    aligned   = {addr[31:2], 2'b00};
    exp_lat   = (bad || (we && size == 2'b00)) ? 1 : 3;
    exp_rd    = (!bad && !(we && size == 2'b00)) ? 1 : 0;
    exp_wr    = (!bad && we) ? 1 : 0;
    exp_rdata = (!bad && !we) ? ref_load(size, sgn, addr) : 32'd0;
    if (!bad && we) ref_store(size, addr, wdata);
    exp_word  = ref_word(addr);

    lat = 0; n_rd = 0; n_wr = 0; rd_at = 0; wr_at = 0;
    got_err = 1'b0; got_rdata = 32'd0; rd_addr = 32'd0; wr_addr = 32'd0; wr_data = 32'd0;

    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // Inputs outside the accept cycle must not matter.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 8; k++) begin
      if (mem_en) begin
        if (mem_we) begin n_wr++; wr_at = k; wr_addr = mem_addr; wr_data = mem_wdata; end
        else        begin n_rd++; rd_at = k; rd_addr = mem_addr; end
      end
      if (rsp_valid) begin
        lat = k; got_err = rsp_err; got_rdata = rsp_rdata;
        break;
      end
      @(negedge clk);
    end

    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"},     32'(got_err), 32'(bad));
    check({tag, "_rdata"},   got_rdata, exp_rdata);
    check({tag, "_nreads"},  n_rd, exp_rd);
    check({tag, "_nwrites"}, n_wr, exp_wr);
    if (exp_rd == 1) begin
      check({tag, "_rd_cycle"}, rd_at, 1);
      check({tag, "_rd_addr"},  rd_addr, aligned);
    end
    if (exp_wr == 1) begin
      check({tag, "_wr_cycle"}, wr_at, exp_lat);
      check({tag, "_wr_addr"},  wr_addr, aligned);
      check({tag, "_wr_data"},  wr_data, exp_word);
    end
    @(posedge clk);
    #1;
    check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_mem"},       tb_mem[addr[5:2]], exp_word);
    o_rdata = got_rdata;
    o_wdata = wr_data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd, wd;
    int          wr0, rsp0, acc0, n;
    logic [31:0] qa [3];
    logic [1:0]  qs [3];
    logic [31:0] qd [3];

    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #3 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    check("rst_ready",     32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed read-modify-write stores and word store.
    set_word(4, 32'hAABBCCDD);
    run_txn("sb_12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h11, rd, wd);
    check("sb_12_spec_word", wd, 32'hAA11CCDD);
    set_word(4, 32'hAABBCCDD);
    run_txn("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, rd, wd);
    check("sh_12_spec_word", wd, 32'h1234CCDD);
    set_word(4, 32'hAABBCCDD);
    run_txn("sw_10", 1'b1, 2'b00, 1'b0, 32'h10, 32'h0102_0304, rd, wd);
    check("sw_10_spec_word", wd, 32'h01020304);

    // Directed loads.
    set_word(4, 32'hAABBCCDD);
    run_txn("lb_13", 1'b0, 2'b10, 1'b1, 32'h13, 32'd0, rd, wd);
    check("lb_13_spec", rd, 32'hFFFFFFAA);
    run_txn("lhu_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'd0, rd, wd);
    check("lhu_10_spec", rd, 32'h0000CCDD);
    run_txn("lbu_11", 1'b0, 2'b10, 1'b0, 32'h11, 32'd0, rd, wd);
    check("lbu_11_spec", rd, 32'h000000CC);

    // Error cases.
    run_txn("err_sh_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'hDEAD_BEEF, rd, wd);
    run_txn("err_sw_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'hDEAD_BEEF, rd, wd);
    run_txn("err_size3", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, rd, wd);
    check("err_spec_mem", tb_mem[4], 32'hAABBCCDD);

    // Reset in the middle of a sub-word store (during WT).
    wr0 = wr_cnt; rsp0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);            // RD
    req_valid = 1'b0;
    @(negedge clk);            // WT
    rst_n = 1'b0;
    #1;
    check("abort_ready",     32'(req_ready), 32'd1);
    check("abort_mem_en",    32'(mem_en),    32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_write", wr_cnt,  wr0);
    check("abort_no_rsp",   rsp_cnt, rsp0);
    check("abort_mem",      tb_mem[4], 32'hAABBCCDD);
    check("abort_ready2",   32'(req_ready), 32'd1);

    // Three stores presented back to back with req_valid held high.
    set_word(8, $urandom);
    qa[0] = 32'h21; qs[0] = 2'b10;
    qa[1] = 32'h20; qs[1] = 2'b01;
    qa[2] = 32'h20; qs[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      qd[i] = $urandom;
      ref_store(qs[i], qa[i], qd[i]);
    end
    wr0 = wr_cnt; acc0 = acc_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_we = 1'b1; req_size = qs[i]; req_signed = 1'b0;
      req_addr = qa[i]; req_wdata = qd[i];
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("queue_wait_bound", 32'(n < 20), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("queue_accepts", acc_cnt - acc0, 3);
    check("queue_writes",  wr_cnt - wr0,   3);
    check("queue_mem",     tb_mem[8],      ref_word(32'h20));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_txn("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
              32'($urandom_range(0, 63)), $urandom, rd, wd);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/store_merge_ctrl.md
STORE_MERGE_CTRL -- requirements
Module: STORE_MERGE_CTRL

Interface
REQ-001 CLK  in  1  single clock; all state updates on rising edge.
REQ-002 RST_N  in  1  asynchronous, active-low reset.
REQ-003 REQ_VALID  in  1  CPU memory request present.
REQ-004 REQ_READY  out  1  controller accepts a request; accept = REQ_VALID & REQ_READY.
REQ-005 REQ_WE  in  1  1 = store, 0 = load.
REQ-006 REQ_SIZE  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
REQ-007 REQ_SIGNED  in  1  loads only: 1 sign-extends, 0 zero-extends.
REQ-008 REQ_ADDR  in  32  byte address, little-endian lanes.
REQ-009 REQ_WDATA  in  32  store data, right-justified for sub-word stores.
REQ-010 RSP_VALID  out  1  one-cycle completion pulse.
REQ-011 RSP_ERR  out  1  valid with RSP_VALID; 1 = misaligned or illegal size.
REQ-012 RSP_RDATA  out  32  load result, extended per REQ_SIGNED; 0 for stores.
REQ-013 MEM_EN  out  1  word-memory access strobe.
REQ-014 MEM_WE  out  1  1 = write when MEM_EN = 1.
REQ-015 MEM_ADDR  out  32  word-aligned address ({REQ_ADDR[31:2], 2'b00}).
REQ-016 MEM_WDATA  out  32  full word to write.
REQ-017 MEM_RDATA  in  32  read data, valid exactly one cycle after a read strobe.

Function
REQ-018 Request fields SHALL be registered on accept; inputs are ignored outside the accept cycle.
REQ-019 States: IDLE, RD, WT, WR, RSP, ERR; REQ_READY = 1 only in IDLE.
REQ-020 Accept-cycle transitions: misaligned or illegal -> ERR; word store -> WR; sub-word store or any load -> RD.
REQ-021 Misaligned: halfword with ADDR[0] = 1; word with ADDR[1:0] != 0; SIZE = 11 is always illegal.
REQ-022 RD: MEM_EN = 1, MEM_WE = 0, one cycle; next state WT.
REQ-023 WT: capture MEM_RDATA; store -> WR, load -> RSP.
REQ-024 WR: MEM_EN = 1, MEM_WE = 1, MEM_WDATA = merged word, RSP_VALID = 1, RSP_ERR = 0; next state IDLE.
REQ-025 Merge: byte lane = ADDR[1:0]; halfword lane = ADDR[1]; merged = (old & ~(mask << 8*lane)) | ((WDATA & mask) << 8*lane), with mask 0x000000FF for byte and 0x0000FFFF for halfword. A word store writes WDATA unchanged.
REQ-026 RSP: RSP_VALID = 1, RSP_RDATA = selected lane extended to 32 bits; next state IDLE.
REQ-027 ERR: RSP_VALID = 1, RSP_ERR = 1, no MEM_EN in any cycle of the transaction; next state IDLE.
REQ-028 Latency from accept cycle T: word store completes at T+1; sub-word store at T+3 (RD at T+1, WT at T+2, WR at T+3); load RSP_VALID at T+3; error at T+1.
REQ-029 Next accept is possible the cycle after completion; no back-to-back overlap and no outstanding-request queue.
REQ-030 MEM_EN SHALL be asserted only in RD and WR; outputs SHALL be 0 in every other state.

Reset
REQ-031 RST_N low SHALL immediately force IDLE, with REQ_READY = 1 and all other outputs 0.
REQ-032 Reset during RD, WT or WR SHALL abort the transaction: no write is issued afterwards and no RSP_VALID is produced for it.

Structure
REQ-033 A shared include/package SHALL hold the REQ_SIZE encodings, the byte/halfword mask constants and the state encodings.
REQ-034 Lane merge and lane extract SHALL live in one combinational sub-module, LANE_MERGE; the FSM stays in STORE_MERGE_CTRL.

Verification
REQ-035 mem[0x10] = 0xAABBCCDD; SB addr 0x12, data 0x11 -> read at T+1, write 0xAA11CCDD to 0x10 at T+3, RSP_VALID at T+3.
REQ-036 Same preload; SH addr 0x12, data 0x00001234 -> write 0x1234CCDD; SW addr 0x10, data 0x01020304 -> single write at T+1, no read.
REQ-037 Loads of 0xAABBCCDD: LB signed addr 0x13 -> 0xFFFFFFAA; LHU addr 0x10 -> 0x0000CCDD; LBU addr 0x11 -> 0x000000CC; each at T+3.
REQ-038 SH addr 0x11, SW addr 0x12, and SIZE = 11 -> RSP_VALID with RSP_ERR = 1 at T+1; MEM_EN stays 0; memory unchanged.
REQ-039 SB issued, RST_N pulsed low during WT -> no write cycle, memory still 0xAABBCCDD, REQ_READY = 1 after reset.
REQ-040 REQ_VALID held high with three queued stores -> each accepted only in IDLE, in order; final memory equals sequential application of all three.
